// File: rtl/bus_master_port_if.sv
// ============================================================================
// Module  : bus_master_port_if
// Purpose : Device-side request and serial system-bus signals of one master port.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface bus_master_port_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic                  d_mode;
    logic                  d_valid;
    logic                  d_ready;
    logic [DATA_WIDTH-1:0] d_rdata;
    logic                  d_err;
    logic                  m_req;
    logic                  m_grant;
    logic                  m_wdata;
    logic                  m_valid;
    logic                  m_mode;
    logic                  ack;
    logic                  s_ready;
    logic                  s_rdata;
    logic                  s_rvalid;

    modport master (
        input  d_addr, d_wdata, d_mode, d_valid, m_grant, ack, s_ready, s_rdata, s_rvalid,
        output d_ready, d_rdata, d_err, m_req, m_wdata, m_valid, m_mode
    );

    modport slave (
        output d_addr, d_wdata, d_mode, d_valid, m_grant, ack, s_ready, s_rdata, s_rvalid,
        input  d_ready, d_rdata, d_err, m_req, m_wdata, m_valid, m_mode
    );
endinterface

`default_nettype wire

// File: rtl/bus_master_port.sv
// ============================================================================
// Module  : bus_master_port
// Purpose : Serialises one parallel read/write request onto the shared bus.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bus_master_port #(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 8,
    parameter int SLAVE_ADDR_WIDTH = 4,
    parameter int ACK_TIMEOUT      = 15
) (
    input  wire logic        clk,
    input  wire logic        rstn,
    bus_master_port_if.master bus
);
    localparam int CNT_W = $clog2((ADDR_WIDTH > ACK_TIMEOUT + 1) ? ADDR_WIDTH : ACK_TIMEOUT + 1);
    localparam int LOW_W = ADDR_WIDTH - SLAVE_ADDR_WIDTH;

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_REQ      = 4'd1;
    localparam logic [3:0] S_SADDR    = 4'd2;
    localparam logic [3:0] S_WAIT_ACK = 4'd3;
    localparam logic [3:0] S_ADDR     = 4'd4;
    localparam logic [3:0] S_WDATA    = 4'd5;
    localparam logic [3:0] S_WAIT_S   = 4'd6;
    localparam logic [3:0] S_RDATA    = 4'd7;
    localparam logic [3:0] S_DONE     = 4'd8;

    logic [3:0]            r_state, w_state_next;
    logic [CNT_W-1:0]      r_cnt, w_addr_idx;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata, r_shift, r_rdata, w_shift_next;
    logic                  r_mode, r_err;
    logic                  w_abort, w_rd_done, w_cnt_inc, w_grant_lost;
    logic                  w_d_ready, w_m_req, w_m_valid, w_m_mode, w_m_wdata;

    // Grant is only watched while the port actually owns the bus.
    assign w_grant_lost = !bus.m_grant && (r_state >= S_SADDR) && (r_state <= S_RDATA);
    assign w_cnt_inc    = (r_state == S_SADDR) || (r_state == S_WAIT_ACK) || (r_state == S_ADDR)
                       || (r_state == S_WDATA) || ((r_state == S_RDATA) && bus.s_rvalid);
    assign w_rd_done    = (r_state == S_RDATA) && bus.s_rvalid && !w_grant_lost
                       && (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign w_shift_next = (r_shift & ~(DATA_WIDTH'(1) << r_cnt))
                        | (DATA_WIDTH'(bus.s_rdata) << r_cnt);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_abort      = 1'b0;
        case (r_state)
            S_IDLE:     if (bus.d_valid) w_state_next = S_REQ;
            S_REQ:      if (bus.m_grant && bus.s_ready) w_state_next = S_SADDR;
            S_SADDR:    if (r_cnt == CNT_W'(SLAVE_ADDR_WIDTH - 1)) w_state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (bus.ack) begin
                    w_state_next = S_ADDR;
                end else if (r_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                    w_state_next = S_DONE;
                    w_abort      = 1'b1;
                end
            end
            S_ADDR:     if (r_cnt == CNT_W'(LOW_W - 1)) w_state_next = r_mode ? S_WDATA : S_RDATA;
            S_WDATA:    if (r_cnt == CNT_W'(DATA_WIDTH - 1)) w_state_next = S_WAIT_S;
            S_WAIT_S:   if (bus.s_ready) w_state_next = S_DONE;
            S_RDATA:    if (w_rd_done) w_state_next = S_DONE;
            S_DONE:     w_state_next = S_IDLE;
            default:    w_state_next = S_IDLE;
        endcase
        if (w_grant_lost) begin
            w_state_next = S_DONE;
            w_abort      = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mode  <= 1'b0;
            r_err   <= 1'b0;
            r_shift <= '0;
            r_rdata <= '0;
        end else begin
            if ((r_state == S_IDLE) && bus.d_valid) begin
                r_addr  <= bus.d_addr;
                r_wdata <= bus.d_wdata;
                r_mode  <= bus.d_mode;
                r_err   <= 1'b0;
            end
            if (w_abort) begin
                r_err <= 1'b1;
            end
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((r_state == S_RDATA) && bus.s_rvalid) begin
                r_shift <= w_shift_next;
            end
            if (w_rd_done) begin
                r_rdata <= w_shift_next;
            end
        end
    end

    // Slave-select field sits in the top address bits but is still sent LSB-first.
    assign w_addr_idx = (r_state == S_SADDR) ? r_cnt + CNT_W'(LOW_W) : r_cnt;

    always_comb begin
        w_d_ready = (r_state == S_IDLE);
        w_m_req   = (r_state >= S_REQ) && (r_state <= S_RDATA);
        w_m_valid = 1'b0;
        w_m_wdata = 1'b0;
        w_m_mode  = ((r_state >= S_SADDR) && (r_state <= S_DONE)) ? r_mode : 1'b0;
        case (r_state)
            S_SADDR, S_ADDR: begin
                w_m_valid = 1'b1;
                w_m_wdata = |(r_addr & (ADDR_WIDTH'(1) << w_addr_idx));
            end
            S_WDATA: begin
                w_m_valid = 1'b1;
                w_m_wdata = |(r_wdata & (DATA_WIDTH'(1) << r_cnt));
            end
            default: begin
                w_m_valid = 1'b0;
                w_m_wdata = 1'b0;
            end
        endcase
    end

    assign bus.d_ready = w_d_ready;
    assign bus.d_rdata = r_rdata;
    assign bus.d_err   = r_err;
    assign bus.m_req   = w_m_req;
    assign bus.m_valid = w_m_valid;
    assign bus.m_wdata = w_m_wdata;
    assign bus.m_mode  = w_m_mode;

endmodule

`default_nettype wire

// File: tb/tb_bus_master_port.sv
// ============================================================================
// Module  : tb_bus_master_port
// Purpose : Directed self-checking bench for bus_master_port.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_bus_master_port;
    logic clk;
    logic rstn;
    int   checks;
    int   errors;

    bus_master_port_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bif ();

    bus_master_port #(
        .ADDR_WIDTH(16), .DATA_WIDTH(8), .SLAVE_ADDR_WIDTH(4), .ACK_TIMEOUT(15)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bif.master)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [15:0] a, input logic [7:0] w, input logic m);
        bif.d_addr  = a;
        bif.d_wdata = w;
        bif.d_mode  = m;
        bif.d_valid = 1'b1;
        tick();
        bif.d_valid = 1'b0;
    endtask

    // Records the serial stream and per-cycle output patterns until the port is idle again.
    task automatic capture(output logic [63:0] stream, output int nbits, output int cycles,
                           output int glitches, output logic [127:0] vpat,
                           output logic [127:0] rpat, output logic [127:0] mpat);
        stream = '0; nbits = 0; cycles = 0; glitches = 0; vpat = '0; rpat = '0; mpat = '0;
        for (int k = 1; k <= 100; k++) begin
            cycles = k;
            if (bif.d_ready === 1'b1) break;
            vpat[k] = bif.m_valid;
            rpat[k] = bif.m_req;
            mpat[k] = bif.m_mode;
            if (bif.m_valid === 1'b1) begin
                if (nbits < 64) stream[nbits] = bif.m_wdata;
                nbits++;
            end else if (bif.m_wdata !== 1'b0) begin
                glitches++;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        tick(); tick();
        checks++; if (bif.d_ready !== 1'b1) begin errors++; $display("FAIL reset_d_ready: got %b expected 1", bif.d_ready); end
        checks++; if (bif.d_rdata !== 8'h00) begin errors++; $display("FAIL reset_d_rdata: got %h expected 00", bif.d_rdata); end
        checks++; if (bif.d_err !== 1'b0) begin errors++; $display("FAIL reset_d_err: got %b expected 0", bif.d_err); end
        checks++; if ({bif.m_req, bif.m_valid, bif.m_wdata, bif.m_mode} !== 4'b0000) begin
            errors++; $display("FAIL reset_bus_outputs: got %b expected 0000", {bif.m_req, bif.m_valid, bif.m_wdata, bif.m_mode}); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_write();
        logic [63:0] s; int n, c, g; logic [127:0] vp, rp, mp;
        issue(16'h1001, 8'hA5, 1'b1);
        capture(s, n, c, g, vp, rp, mp);
        checks++; if (c !== 29) begin errors++; $display("FAIL write_latency: got %0d expected 29", c); end
        checks++; if (n !== 24) begin errors++; $display("FAIL write_nbits: got %0d expected 24", n); end
        checks++; if (s[23:0] !== 24'hA50011) begin errors++; $display("FAIL write_stream: got %h expected a50011", s[23:0]); end
        checks++; if (vp[31:0] !== 32'h07FFFFBC) begin errors++; $display("FAIL write_valid_pattern: got %h expected 07ffffbc", vp[31:0]); end
        checks++; if (rp[31:0] !== 32'h0FFFFFFE) begin errors++; $display("FAIL write_req_pattern: got %h expected 0ffffffe", rp[31:0]); end
        checks++; if (mp[31:0] !== 32'h1FFFFFFC) begin errors++; $display("FAIL write_mode_pattern: got %h expected 1ffffffc", mp[31:0]); end
        checks++; if (g !== 0) begin errors++; $display("FAIL write_idle_wdata: got %0d expected 0", g); end
        checks++; if (bif.d_err !== 1'b0) begin errors++; $display("FAIL write_d_err: got %b expected 0", bif.d_err); end
    endtask

    task automatic test_read();
        logic [63:0] s; int n; logic [7:0] rd;
        s = '0; n = 0; rd = 8'h3C;
        issue(16'h2003, 8'h00, 1'b0);
        for (int k = 1; k <= 18; k++) begin
            if (bif.m_valid === 1'b1) begin s[n] = bif.m_wdata; n++; end
            tick();
        end
        checks++; if (s[15:0] !== 16'h0032 || n !== 16) begin errors++; $display("FAIL read_addr_stream: got %h/%0d expected 0032/16", s[15:0], n); end
        for (int i = 0; i < 8; i++) begin
            if (i == 7) begin
                checks++; if (bif.d_rdata !== 8'h00) begin errors++; $display("FAIL read_no_partial: got %h expected 00", bif.d_rdata); end
            end
            bif.s_rvalid = 1'b1;
            bif.s_rdata  = rd[i];
            tick();
            if (i == 3) begin
                bif.s_rvalid = 1'b0;
                tick(); tick();
            end
        end
        bif.s_rvalid = 1'b0;
        bif.s_rdata  = 1'b0;
        checks++; if (bif.d_rdata !== 8'h3C) begin errors++; $display("FAIL read_d_rdata: got %h expected 3c", bif.d_rdata); end
        checks++; if (bif.m_req !== 1'b0) begin errors++; $display("FAIL read_done_req: got %b expected 0", bif.m_req); end
        tick();
        checks++; if (bif.d_ready !== 1'b1 || bif.d_err !== 1'b0) begin
            errors++; $display("FAIL read_end_state: got ready=%b err=%b expected ready=1 err=0", bif.d_ready, bif.d_err); end
    endtask

    task automatic test_ack_timeout();
        logic [63:0] s; int n; logic req20, err20;
        s = '0; n = 0; req20 = 1'b0; err20 = 1'b1;
        bif.ack = 1'b0;
        issue(16'h5123, 8'h00, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            if (bif.m_valid === 1'b1) begin s[n] = bif.m_wdata; n++; end
            if (k == 20) begin req20 = bif.m_req; err20 = bif.d_err; end
            tick();
        end
        checks++; if (req20 !== 1'b1 || err20 !== 1'b0) begin
            errors++; $display("FAIL timeout_still_waiting: got req=%b err=%b expected req=1 err=0", req20, err20); end
        checks++; if (bif.m_req !== 1'b0 || bif.d_err !== 1'b1 || bif.d_ready !== 1'b0) begin
            errors++; $display("FAIL timeout_done: got req=%b err=%b ready=%b expected 0 1 0", bif.m_req, bif.d_err, bif.d_ready); end
        checks++; if (n !== 4 || s[3:0] !== 4'h5) begin errors++; $display("FAIL timeout_bits_sent: got %0d bits %h expected 4 bits 5", n, s[3:0]); end
        tick();
        checks++; if (bif.d_ready !== 1'b1 || bif.d_rdata !== 8'h3C) begin
            errors++; $display("FAIL timeout_idle: got ready=%b rdata=%h expected 1 3c", bif.d_ready, bif.d_rdata); end
        bif.ack = 1'b1;
    endtask

    task automatic test_grant_loss();
        logic [63:0] s; int n, c, g; logic [127:0] vp, rp, mp;
        issue(16'h1234, 8'h5A, 1'b1);
        for (int k = 1; k <= 11; k++) tick();
        checks++; if (bif.m_valid !== 1'b1 || bif.m_wdata !== 1'b1) begin
            errors++; $display("FAIL grant_loss_6th_bit: got valid=%b bit=%b expected 1 1", bif.m_valid, bif.m_wdata); end
        bif.m_grant = 1'b0;
        tick();
        checks++; if (bif.m_valid !== 1'b0 || bif.m_req !== 1'b0 || bif.d_err !== 1'b1) begin
            errors++; $display("FAIL grant_loss_abort: got valid=%b req=%b err=%b expected 0 0 1", bif.m_valid, bif.m_req, bif.d_err); end
        bif.m_grant = 1'b1;
        tick();
        checks++; if (bif.d_ready !== 1'b1 || bif.d_rdata !== 8'h3C) begin
            errors++; $display("FAIL grant_loss_idle: got ready=%b rdata=%h expected 1 3c", bif.d_ready, bif.d_rdata); end
        issue(16'h1001, 8'hA5, 1'b1);
        checks++; if (bif.d_err !== 1'b0) begin errors++; $display("FAIL grant_loss_err_clear: got %b expected 0", bif.d_err); end
        capture(s, n, c, g, vp, rp, mp);
        checks++; if (c !== 29 || s[23:0] !== 24'hA50011 || bif.d_err !== 1'b0) begin
            errors++; $display("FAIL grant_loss_followup: got cyc=%0d stream=%h err=%b expected 29 a50011 0", c, s[23:0], bif.d_err); end
    endtask

    task automatic test_arb_wait();
        logic [63:0] s; int n, c, g, bad; logic [127:0] vp, rp, mp;
        bad = 0;
        bif.m_grant = 1'b0;
        issue(16'h3456, 8'h81, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            if (bif.m_req !== 1'b1 || bif.m_valid !== 1'b0) bad++;
            if (k == 5) begin bif.d_addr = 16'hFFFF; bif.d_wdata = 8'h00; bif.d_mode = 1'b0; bif.d_valid = 1'b1; end
            if (k == 8) bif.d_valid = 1'b0;
            tick();
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL arb_wait_hold: got %0d bad cycles expected 0", bad); end
        bif.m_grant = 1'b1;
        capture(s, n, c, g, vp, rp, mp);
        checks++; if (c !== 29 || n !== 24) begin errors++; $display("FAIL arb_wait_timing: got cyc=%0d bits=%0d expected 29 24", c, n); end
        checks++; if (s[23:0] !== 24'h814563) begin errors++; $display("FAIL arb_wait_stream: got %h expected 814563", s[23:0]); end
    endtask

    task automatic test_async_reset();
        logic [63:0] s; int n, c, g; logic [127:0] vp, rp, mp;
        issue(16'h1001, 8'hFF, 1'b1);
        for (int k = 1; k <= 20; k++) tick();
        checks++; if (bif.m_valid !== 1'b1 || bif.m_wdata !== 1'b1) begin
            errors++; $display("FAIL areset_in_wdata: got valid=%b bit=%b expected 1 1", bif.m_valid, bif.m_wdata); end
        #2 rstn = 1'b0;
        #1;
        checks++; if ({bif.m_req, bif.m_valid, bif.m_wdata} !== 3'b000) begin
            errors++; $display("FAIL areset_bus_drop: got %b expected 000", {bif.m_req, bif.m_valid, bif.m_wdata}); end
        checks++; if (bif.d_ready !== 1'b1 || bif.d_rdata !== 8'h00) begin
            errors++; $display("FAIL areset_device: got ready=%b rdata=%h expected 1 00", bif.d_ready, bif.d_rdata); end
        tick();
        rstn = 1'b1;
        tick();
        issue(16'h1001, 8'hA5, 1'b1);
        capture(s, n, c, g, vp, rp, mp);
        checks++; if (c !== 29 || s[23:0] !== 24'hA50011 || bif.d_err !== 1'b0) begin
            errors++; $display("FAIL areset_recovery: got cyc=%0d stream=%h err=%b expected 29 a50011 0", c, s[23:0], bif.d_err); end
    endtask

    initial begin
        clk = 1'b0; rstn = 1'b0; checks = 0; errors = 0;
        bif.d_addr = '0; bif.d_wdata = '0; bif.d_mode = 1'b0; bif.d_valid = 1'b0;
        bif.m_grant = 1'b1; bif.ack = 1'b1; bif.s_ready = 1'b1;
        bif.s_rdata = 1'b0; bif.s_rvalid = 1'b0;
        test_reset();
        test_write();
        test_read();
        test_ack_timeout();
        test_grant_loss();
        test_arb_wait();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
